// File: rtl/cpu_seq_pkg.sv
// Shared types and opcode constants for the multi-cycle CPU sequencer.
// State enum order defines the externally visible phase encoding.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    OpRtype,
    OpAddi,
    OpLw,
    OpSw,
    OpBeq,
    OpJ,
    OpIllegal
  } op_class_e;

  localparam logic [5:0] OpcRtype = 6'h00;
  localparam logic [5:0] OpcAddi  = 6'h08;
  localparam logic [5:0] OpcLw    = 6'h23;
  localparam logic [5:0] OpcSw    = 6'h2B;
  localparam logic [5:0] OpcBeq   = 6'h04;
  localparam logic [5:0] OpcJ     = 6'h02;

  function automatic op_class_e decode_opcode(logic [5:0] opc);
    op_class_e cls;
    case (opc)
      OpcRtype: cls = OpRtype;
      OpcAddi:  cls = OpAddi;
      OpcLw:    cls = OpLw;
      OpcSw:    cls = OpSw;
      OpcBeq:   cls = OpBeq;
      OpcJ:     cls = OpJ;
      default:  cls = OpIllegal;
    endcase
    return cls;
  endfunction

  // Control-flow classes finish in EXEC; everything else goes on to MEM or WB.
  function automatic logic is_ctrl_flow(op_class_e cls);
    return (cls == OpBeq) || (cls == OpJ);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and the datapath around it.
// master: the sequencer (drives strobes); slave: datapath/environment.
interface cpu_sequencer_if;
  logic        start;
  logic [31:0] entry_point;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        halt_req;

  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        reg_write_en;
  logic [2:0]  phase;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [31:0] instr_count;

  modport master (
    input  start, entry_point, opcode, mem_ready, halt_req,
    output pc_load, pc_load_addr, pc_write, ir_write, mem_read_en, mem_write_en,
    output reg_write_en, phase, busy, halted, illegal, instr_count
  );

  modport slave (
    output start, entry_point, opcode, mem_ready, halt_req,
    input  pc_load, pc_load_addr, pc_write, ir_write, mem_read_en, mem_write_en,
    input  reg_write_en, phase, busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/seq_opdecode.sv
// Combinational opcode -> op-class decoder.
module seq_opdecode
  import cpu_seq_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_e  op_class_o
);

  always_comb begin
    op_class_o = decode_opcode(opcode_i);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: Moore FSM driving PC/IR/memory/regfile strobes.
// Halt requests are remembered and honoured only at an instruction boundary (retire).
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned MAX_INSTR = 0
) (
  input logic             clk,
  input logic             rst_n,
  cpu_sequencer_if.master bus
);

  state_e      state_q, state_d;
  op_class_e   op_class_q, op_class_d;
  op_class_e   dec_class;
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] count_inc;
  logic        illegal_q, illegal_d;
  logic        halt_pend_q, halt_pend_d;
  logic        retire;
  logic        max_hit;

  seq_opdecode u_opdecode (
    .opcode_i   (bus.opcode),
    .op_class_o (dec_class)
  );

  assign count_inc = instr_count_q + 32'd1;
  assign max_hit   = (MAX_INSTR != 0) && (count_inc == MAX_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_class_q    <= OpRtype;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
      halt_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_class_q    <= op_class_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
      halt_pend_q   <= halt_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_class_d    = op_class_q;
    instr_count_d = instr_count_q;
    illegal_d     = illegal_q;
    halt_pend_d   = halt_pend_q;
    retire        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        instr_count_d = '0;
        illegal_d     = 1'b0;
        halt_pend_d   = 1'b0;
        state_d       = StFetch;
      end
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        op_class_d = dec_class;
        state_d    = StExec;
      end
      StExec: begin
        case (op_class_q)
          OpBeq, OpJ:      retire  = 1'b1;
          OpLw, OpSw:      state_d = StMem;
          OpRtype, OpAddi: state_d = StWb;
          default: begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        endcase
      end
      StMem: begin
        if (bus.mem_ready) begin
          if (op_class_q == OpLw) state_d = StWb;
          else                    retire  = 1'b1;
        end
      end
      StWb: begin
        retire = 1'b1;
      end
      StHalt: begin
        if (bus.start) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase

    // A request seen mid-instruction is held until the instruction retires.
    if (bus.halt_req && (state_q inside {StFetch, StDecode, StExec, StMem, StWb})) begin
      halt_pend_d = 1'b1;
    end

    if (retire) begin
      instr_count_d = count_inc;
      halt_pend_d   = 1'b0;
      state_d       = (bus.halt_req || halt_pend_q || max_hit) ? StHalt : StFetch;
    end
  end

  // Moore outputs: decoded from registered state and op class only.
  always_comb begin
    bus.pc_load      = 1'b0;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.reg_write_en = 1'b0;

    unique case (state_q)
      StLoad:  bus.pc_load = 1'b1;
      StFetch: begin
        bus.ir_write = 1'b1;
        bus.pc_write = 1'b1;
      end
      StExec:  bus.pc_write = is_ctrl_flow(op_class_q);
      StMem: begin
        bus.mem_read_en  = (op_class_q == OpLw);
        bus.mem_write_en = (op_class_q == OpSw);
      end
      StWb:    bus.reg_write_en = 1'b1;
      default: ;
    endcase

    bus.pc_load_addr = bus.pc_load ? bus.entry_point : 32'd0;
    bus.phase        = state_q;
    bus.busy         = (state_q != StIdle) && (state_q != StHalt);
    bus.halted       = (state_q == StHalt);
    bus.illegal      = illegal_q;
    bus.instr_count  = instr_count_q;
  end

  strobe_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({bus.pc_load, bus.ir_write, bus.mem_read_en, bus.mem_write_en, bus.reg_write_en}));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction scoreboard of latency,
// strobe counts, retire count and end phase, plus reset and auto-halt scenarios.
module tb_cpu_sequencer;

  localparam logic [2:0] PhIdle  = 3'd0;
  localparam logic [2:0] PhLoad  = 3'd1;
  localparam logic [2:0] PhFetch = 3'd2;
  localparam logic [2:0] PhExec  = 3'd4;
  localparam logic [2:0] PhMem   = 3'd5;
  localparam logic [2:0] PhHalt  = 3'd7;

  typedef struct {
    string       tag;
    int          cycles;
    logic [31:0] count;
    logic [2:0]  phase;
    int          n_regw;
    int          n_rd;
    int          n_wr;
    int          n_pcw;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_count = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  cpu_sequencer_if bus ();
  cpu_sequencer_if bus2 ();

  cpu_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cpu_sequencer #(
    .MAX_INSTR (43)
  ) u_dut_max (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic int exp_cycles(input logic [5:0] opc, input int w);
    case (opc)
      6'h00, 6'h08: return 4;
      6'h04, 6'h02: return 3;
      6'h2B:        return 4 + w;
      6'h23:        return 5 + w;
      default:      return 3;
    endcase
  endfunction

  // Call at a negedge with the DUT idle or halted.
  task automatic do_start(input logic [31:0] ep);
    bus.start       = 1'b1;
    bus.entry_point = ep;
    @(negedge clk);
    bus.start = 1'b0;
    check("load_phase", bus.phase, PhLoad);
    check("load_pc_load", bus.pc_load, 1);
    check("load_addr", bus.pc_load_addr, ep);
    @(negedge clk);
    check("fetch_phase", bus.phase, PhFetch);
    check("fetch_pc_load_low", bus.pc_load, 0);
    check("start_count_clear", bus.instr_count, 0);
    check("start_illegal_clear", bus.illegal, 0);
    model_count = 0;
  endtask

  // Call at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH/HALT.
  task automatic run_instr(input logic [5:0] opc, input int w, input bit hreq);
    exp_t e;
    int   cyc, mem_seen, nrw, nr, nw, npw;
    bit   done, legal, is_lw, is_sw;
    legal = opc inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    is_lw = (opc == 6'h23);
    is_sw = (opc == 6'h2B);
    e.tag     = $sformatf("op%02h", opc);
    e.cycles  = exp_cycles(opc, w);
    e.count   = legal ? model_count + 1 : model_count;
    e.phase   = (!legal || hreq) ? PhHalt : PhFetch;
    e.n_regw  = (opc inside {6'h00, 6'h08, 6'h23}) ? 1 : 0;
    e.n_rd    = is_lw ? w + 1 : 0;
    e.n_wr    = is_sw ? w + 1 : 0;
    e.n_pcw   = (opc inside {6'h04, 6'h02}) ? 1 : 0;
    e.illegal = !legal;
    sb_q.push_back(e);

    check({e.tag, "_ir_write"}, bus.ir_write, 1);
    check({e.tag, "_fetch_pc_write"}, bus.pc_write, 1);
    bus.opcode    = opc;
    bus.mem_ready = 1'b0;
    bus.halt_req  = 1'b0;
    cyc = 0; mem_seen = 0; nrw = 0; nr = 0; nw = 0; npw = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (bus.phase inside {PhFetch, PhHalt, PhIdle}) begin
        done = 1'b1;
      end else begin
        nrw += int'(bus.reg_write_en);
        nr  += int'(bus.mem_read_en);
        nw  += int'(bus.mem_write_en);
        npw += int'(bus.pc_write);
        check({e.tag, "_onehot"}, 32'($onehot0({bus.pc_load, bus.ir_write, bus.mem_read_en,
              bus.mem_write_en, bus.reg_write_en})), 1);
        bus.halt_req  = hreq && (bus.phase == PhExec);
        bus.mem_ready = 1'b0;
        if (bus.phase == PhMem) begin
          bus.mem_ready = (mem_seen == w);
          mem_seen++;
        end
      end
    end
    bus.mem_ready = 1'b0;
    bus.halt_req  = 1'b0;

    e = sb_q.pop_front();
    check({e.tag, "_finished"}, 32'(done), 1);
    check({e.tag, "_cycles"}, cyc, e.cycles);
    check({e.tag, "_count"}, bus.instr_count, e.count);
    check({e.tag, "_end_phase"}, bus.phase, e.phase);
    check({e.tag, "_halted"}, bus.halted, (e.phase == PhHalt));
    check({e.tag, "_reg_write"}, nrw, e.n_regw);
    check({e.tag, "_mem_read"}, nr, e.n_rd);
    check({e.tag, "_mem_write"}, nw, e.n_wr);
    check({e.tag, "_exec_pc_write"}, npw, e.n_pcw);
    check({e.tag, "_illegal"}, bus.illegal, e.illegal);
    model_count = e.count;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cyc;
    bit   done;
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.entry_point = '0;  bus.opcode = '0;
    bus.mem_ready = 1'b0;  bus.halt_req = 1'b0;
    bus2.start = 1'b0; bus2.entry_point = '0; bus2.opcode = '0;
    bus2.mem_ready = 1'b0; bus2.halt_req = 1'b0;

    @(negedge clk);
    check("rst_phase", bus.phase, PhIdle);
    check("rst_count", bus.instr_count, 0);
    check("rst_strobes", {bus.pc_load, bus.pc_write, bus.ir_write, bus.mem_read_en,
          bus.mem_write_en, bus.reg_write_en}, 0);
    check("rst_flags", {bus.busy, bus.halted, bus.illegal}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold_phase", bus.phase, PhIdle);
    check("idle_hold_pc_load", bus.pc_load, 0);
    check("idle_busy", bus.busy, 0);

    do_start(32'd128);
    check("fetch_busy", bus.busy, 1);
    run_instr(6'h00, 0, 1'b0);
    run_instr(6'h23, 2, 1'b0);
    run_instr(6'h2B, 1, 1'b0);
    run_instr(6'h04, 0, 1'b0);
    check("seq4_count", bus.instr_count, 4);
    run_instr(6'h08, 0, 1'b0);
    run_instr(6'h02, 0, 1'b0);
    run_instr(6'h2B, 0, 1'b0);
    run_instr(6'h23, 0, 1'b0);
    run_instr(6'h3F, 0, 1'b0);

    // HALT ignores halt_req and stray mem_ready.
    bus.halt_req  = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.halt_req  = 1'b0;
    bus.mem_ready = 1'b0;
    check("halt_stays", bus.phase, PhHalt);
    check("halt_busy", bus.busy, 0);
    check("halt_illegal_held", bus.illegal, 1);

    do_start(32'd256);
    run_instr(6'h23, 1, 1'b1);

    // Reset while an LW waits on memory.
    do_start(32'd0);
    bus.opcode = 6'h23;
    cyc = 0;
    while (bus.phase != PhMem && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_mem", bus.phase, PhMem);
    check("mem_rd_before_rst", bus.mem_read_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_read_drop", bus.mem_read_en, 0);
    check("rst_mid_phase", bus.phase, PhIdle);
    check("rst_mid_count", bus.instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Auto-halt after 43 RTYPE retires.
    e.tag = "max43"; e.cycles = 172; e.count = 43; e.phase = PhHalt;
    e.n_regw = 0; e.n_rd = 0; e.n_wr = 0; e.n_pcw = 0; e.illegal = 1'b0;
    sb_q.push_back(e);
    bus2.opcode = 6'h00;
    bus2.start  = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    @(negedge clk);
    check("max43_first_fetch", bus2.phase, PhFetch);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus2.halted) done = 1'b1;
    end
    e = sb_q.pop_front();
    check({e.tag, "_halted"}, 32'(done), 1);
    check({e.tag, "_cycles"}, cyc, e.cycles);
    check({e.tag, "_count"}, bus2.instr_count, e.count);
    check({e.tag, "_phase"}, bus2.phase, e.phase);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: MAX_INSTR, default 0, retire limit before auto-halt (0 = unlimited).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin or restart execution from entry_point; honoured in IDLE/HALT only.
REQ-005 entry_point  input  32  PC load value, passed through to the PC path during LOAD.
REQ-006 opcode  input  6  instruction[31:26] from the instruction register, valid from DECODE onward.
REQ-007 mem_ready  input  1  data-memory completion handshake.
REQ-008 halt_req  input  1  request to stop at the next instruction boundary.
REQ-009 pc_load  output  1  load PC from entry_point.
REQ-010 pc_write  output  1  PC update enable (PC+4 in FETCH; branch/jump target in EXEC).
REQ-011 ir_write  output  1  instruction register capture.
REQ-012 mem_read_en / mem_write_en  output  1 each  data-memory strobes.
REQ-013 reg_write_en  output  1  register-file write enable.
REQ-014 phase  output  3  current state encoding.
REQ-015 busy / halted / illegal  output  1 each  status flags.
REQ-016 instr_count  output  32  retired-instruction counter.

Function
REQ-017 States: IDLE, LOAD, FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs are Moore, decoded from the registered state and op class only.
REQ-018 IDLE: start=1 -> LOAD; otherwise hold.
REQ-019 LOAD: pc_load=1 for exactly one cycle, instr_count cleared to 0, illegal cleared -> FETCH.
REQ-020 FETCH: ir_write=1, pc_write=1 -> DECODE.
REQ-021 DECODE: opcode latched into an op-class register; class is RTYPE (0x00), ADDI (0x08), LW (0x23), SW (0x2B), BEQ (0x04), J (0x02), ILLEGAL (any other value) -> EXEC.
REQ-022 EXEC: pc_write=1 only for BEQ/J; ILLEGAL -> HALT with illegal=1 and no retire; BEQ/J retire -> FETCH; LW/SW -> MEM; RTYPE/ADDI -> WB.
REQ-023 MEM: mem_read_en=1 (LW) or mem_write_en=1 (SW), held until mem_ready=1; mem_ready=1 -> WB for LW, or retire -> FETCH for SW; a mem_ready arriving in any other state is ignored.
REQ-024 WB: reg_write_en=1 for one cycle, then retire -> FETCH.
REQ-025 Retire: instr_count increments by 1, wrapping modulo 2^32.
REQ-026 Retire redirect: the retire target is HALT instead of FETCH if halt_req=1 in the retiring cycle, or if MAX_INSTR!=0 and the post-increment count equals MAX_INSTR.
REQ-027 HALT: halted=1; start=1 -> LOAD; halt_req has no effect in HALT.
REQ-028 halt_req asserted mid-instruction does not abort the instruction; it is acted on only at retire.
REQ-029 busy=1 in every state except IDLE and HALT.
REQ-030 Every strobe output is 0 in states not listed for it; at most one of pc_load, ir_write, mem_read_en, mem_write_en, reg_write_en is 1 in any cycle.
REQ-031 Per-class latency, FETCH to next FETCH: RTYPE/ADDI 4 cycles; BEQ/J 3 cycles; SW 4+w cycles; LW 5+w cycles (w = MEM wait cycles).

Reset
REQ-032 rst_n=0 forces, asynchronously: state=IDLE, instr_count=0, illegal=0, op class=RTYPE, and all strobes and flags 0.
REQ-033 Reset asserted mid-MEM drops the memory strobes immediately, without waiting for mem_ready.
REQ-034 After rst_n deasserts, no activity occurs until start=1.

Structure
REQ-035 Package cpu_seq_pkg holds the state enum, the op-class enum, and the opcode constants (0x00, 0x08, 0x23, 0x2B, 0x04, 0x02).
REQ-036 One sub-module, seq_opdecode: combinational opcode -> op class, instantiated once.
REQ-037 The phase encoding follows the state-enum order in the package: IDLE=0 ... HALT=7.

Verification
REQ-038 Reset then start with entry_point=128 -> pc_load high for exactly one cycle, then FETCH with ir_write=1 and pc_write=1.
REQ-039 Opcode sequence 0x00, 0x23 (mem_ready delayed 2 cycles), 0x2B, 0x04 -> phases and strobes as in REQ-031; instr_count=4; LW spans 7 cycles.
REQ-040 Opcode 0x3F -> HALT after EXEC, illegal=1, instr_count unchanged, no reg_write_en; a following start clears illegal.
REQ-041 MAX_INSTR=43 with RTYPE only -> halted=1 at instr_count=43, after exactly 172 cycles measured from the first FETCH.
REQ-042 halt_req pulsed during EXEC of an LW -> MEM and WB complete, then HALT with the count incremented.
REQ-043 rst_n low during MEM wait -> mem_read_en=0 in the same cycle, phase=0, instr_count=0.
